// File: rtl/ex_stage_pipe.sv
// Execute stage: decode, ALU, branch target/resolve and iterative multiply; latency 1 (multiply DATA_W+1).
// Backpressure: in_ready drops while a multiply runs or while a held result is not being drained.
module ex_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] bus_a,
  input  logic [DATA_W-1:0] bus_b,
  input  logic [IMM_W-1:0]  imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8:0]        signals,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero,
  output logic [DATA_W-1:0] br_add,
  output logic              br_taken
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  typedef struct packed {
    logic [8:0]        signals;
    logic [DATA_W-1:0] alu_out;
    logic              zero;
    logic [DATA_W-1:0] br_add;
    logic              br_taken;
  } res_t;

  state_t            state_q, state_d;
  res_t              res_q, res_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mul_br_add_q, mul_br_add_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [5:0]        funct;
  logic [8:0]        sig_c;
  logic              dec_known;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] alu_c;
  logic [DATA_W-1:0] br_add_c;
  logic [DATA_W-1:0] mul_sum;
  logic              is_beq;
  logic              is_mul;
  logic              zero_c;
  logic              br_taken_c;
  logic              accept;

  assign funct    = imm[5:0];
  assign imm_sext = DATA_W'($signed(imm));
  assign br_add_c = pc + (imm_sext << 2);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_mul   = (MUL_EN != 0) && (opcode == OP_R) && (funct == FN_MUL);

  // Main decode; signals = {RegDst,RegWrite,ALUSrc,Branch,MemRead,MemWrite,MemtoReg,ALUOp[1:0]}
  always_comb begin
    sig_c     = 9'h000;
    dec_known = 1'b1;
    case (opcode)
      OP_R:           sig_c = 9'h182;
      OP_ADDI:        sig_c = 9'h0C0;
      OP_LW:          sig_c = 9'h0D4;
      OP_SW:          sig_c = 9'h048;
      OP_BEQ, OP_BNE: sig_c = 9'h021;
      default:        dec_known = 1'b0;
    endcase
  end

  assign opb = sig_c[6] ? imm_sext : bus_b;

  // Multiply funct leaves alu_c at 0 here; its result comes from the iterative path.
  always_comb begin
    alu_c = '0;
    if (dec_known) begin
      case (sig_c[1:0])
        2'b00: alu_c = bus_a + opb;
        2'b01: alu_c = bus_a - opb;
        2'b10: begin
          case (funct)
            FN_ADD:  alu_c = bus_a + opb;
            FN_SUB:  alu_c = bus_a - opb;
            FN_AND:  alu_c = bus_a & opb;
            FN_OR:   alu_c = bus_a | opb;
            FN_NOR:  alu_c = ~(bus_a | opb);
            FN_SLT:  alu_c = {{(DATA_W-1){1'b0}}, ($signed(bus_a) < $signed(opb))};
            default: alu_c = '0;
          endcase
        end
        default: alu_c = '0;
      endcase
    end
  end

  assign zero_c     = (alu_c == '0);
  assign br_taken_c = sig_c[5] & (is_beq ? zero_c : ~zero_c);
  assign mul_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign in_ready = !reset && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    res_d        = res_q;
    out_valid_d  = out_valid_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    mul_br_add_d = mul_br_add_q;
    cnt_d        = cnt_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mcand_d      = bus_a;
            mplier_d     = bus_b;
            acc_d        = '0;
            cnt_d        = '0;
            mul_br_add_d = br_add_c;
            state_d      = ST_MUL;
          end else begin
            res_d.signals  = sig_c;
            res_d.alu_out  = alu_c;
            res_d.zero     = zero_c;
            res_d.br_add   = br_add_c;
            res_d.br_taken = br_taken_c;
            out_valid_d    = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          res_d.signals  = 9'h182;
          res_d.alu_out  = mul_sum;
          res_d.zero     = (mul_sum == '0);
          res_d.br_add   = mul_br_add_q;
          res_d.br_taken = 1'b0;
          out_valid_d    = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      res_q        <= '0;
      out_valid_q  <= 1'b0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      mul_br_add_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      res_q        <= res_d;
      out_valid_q  <= out_valid_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      mul_br_add_q <= mul_br_add_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign signals   = res_q.signals;
  assign alu_out   = res_q.alu_out;
  assign zero      = res_q.zero;
  assign br_add    = res_q.br_add;
  assign br_taken  = res_q.br_taken;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: directed scenarios, then random valid/ready traffic against a scoreboard.
module tb_ex_stage_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [31:0] pc, bus_a, bus_b;
  logic [15:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  signals;
  logic [31:0] alu_out;
  logic        zero;
  logic [31:0] br_add;
  logic        br_taken;

  ex_stage_pipe #(.DATA_W(32), .IMM_W(16), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .pc(pc), .bus_a(bus_a), .bus_b(bus_b), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .signals(signals),
    .alu_out(alu_out), .zero(zero), .br_add(br_add), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  sig;
    logic [31:0] alu;
    logic        z;
    logic [31:0] bra;
    logic        bt;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  bit   acc_seen = 1'b0;
  bit   hold_v = 1'b0;
  logic [74:0] snap;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: instruction semantics computed directly from opcode/funct numbers.
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] pcv,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [15:0] im);
    exp_t e;
    logic [31:0] sx;
    sx = {{16{im[15]}}, im};
    e = '0;
    e.bra = pcv + sx * 32'd4;
    case (op)
      6'd0: begin
        e.sig = 9'h182;
        case (im[5:0])
          6'd32:   e.alu = a + b;
          6'd34:   e.alu = a - b;
          6'd36:   e.alu = a & b;
          6'd37:   e.alu = a | b;
          6'd39:   e.alu = ~(a | b);
          6'd42:   e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'd24:   e.alu = a * b;
          default: e.alu = 32'd0;
        endcase
      end
      6'd8:  begin e.sig = 9'h0C0; e.alu = a + sx; end
      6'd35: begin e.sig = 9'h0D4; e.alu = a + sx; end
      6'd43: begin e.sig = 9'h048; e.alu = a + sx; end
      6'd4, 6'd5: begin e.sig = 9'h021; e.alu = a - b; end
      default: begin e.sig = 9'h000; e.alu = 32'd0; end
    endcase
    e.z  = (e.alu == 32'd0);
    e.bt = (op == 6'd4) ? e.z : (op == 6'd5) ? !e.z : 1'b0;
    return e;
  endfunction

  task automatic check_res(input string tag, input exp_t e);
    check({tag, ".sig"}, signals, e.sig);
    check({tag, ".alu"}, alu_out, e.alu);
    check({tag, ".zero"}, zero, e.z);
    check({tag, ".bradd"}, br_add, e.bra);
    check({tag, ".taken"}, br_taken, e.bt);
  endtask

  // Single-cycle instruction with the sink always ready; result checked one cycle later.
  task automatic do_one(input string tag, input logic [5:0] op, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
    @(posedge clk); #1;
    opcode = op; pc = p; bus_a = a; bus_b = b; imm = im;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".in_rdy"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, ".vld"}, out_valid, 1'b1);
    check_res(tag, model(op, p, a, b, im));
  endtask

  task automatic rand_txn();
    logic [5:0] fn_tab [8];
    fn_tab = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd24, 6'd0};
    case ($urandom_range(0, 9))
      0, 1, 2, 3: opcode = 6'd0;
      4: opcode = 6'd8;
      5: opcode = 6'd35;
      6: opcode = 6'd43;
      7: opcode = 6'd4;
      8: opcode = 6'd5;
      default: opcode = 6'($urandom);
    endcase
    pc  = $urandom;
    imm = 16'($urandom);
    if (opcode == 6'd0) begin
      fn_tab[7] = 6'($urandom);
      imm[5:0] = fn_tab[$urandom_range(0, 7)];
    end
    bus_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
    bus_b = ($urandom_range(0, 2) == 0) ? bus_a : $urandom;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_v) begin
        check("hold.vld", out_valid, 1'b1);
        check("hold.dat", {signals, alu_out, zero, br_add, br_taken}, snap);
      end
      hold_v = out_valid && !out_ready;
      snap   = {signals, alu_out, zero, br_add, br_taken};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb.extra", 1'b1, 1'b0);
        else check_res("sb", exp_q.pop_front());
      end
      acc_seen = in_valid && in_ready;
      if (acc_seen) exp_q.push_back(model(opcode, pc, bus_a, bus_b, imm));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy, ghost;
    exp_t e;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; pc = '0; bus_a = '0; bus_b = '0; imm = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.in_rdy", in_ready, 1'b0);
    check("rst.vld", out_valid, 1'b0);
    check("rst.sig", signals, 9'h000);
    check("rst.alu", alu_out, 32'd0);
    check("rst.bradd", br_add, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rel.in_rdy", in_ready, 1'b1);

    do_one("add", 6'd0, 32'd0, 32'd4, 32'd3, 16'h0020);
    do_one("sub", 6'd0, 32'd0, 32'd3, 32'd3, 16'h0022);
    do_one("slt", 6'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 16'h002A);
    do_one("slt0", 6'd0, 32'd0, 32'd1, 32'hFFFF_FFFF, 16'h002A);
    do_one("and", 6'd0, 32'd0, 32'h0000_F0F0, 32'h0000_0FF0, 16'h0024);
    do_one("or", 6'd0, 32'd0, 32'h0000_F0F0, 32'h0000_0FF0, 16'h0025);
    do_one("nor", 6'd0, 32'd0, 32'h0000_F0F0, 32'h0000_0FF0, 16'h0027);
    do_one("badfn", 6'd0, 32'd0, 32'd9, 32'd9, 16'h003F);
    do_one("beq", 6'd4, 32'd3, 32'h3B, 32'h33, 16'h0025);
    do_one("bne", 6'd5, 32'd3, 32'h3B, 32'h33, 16'h0025);
    do_one("beqz", 6'd4, 32'h40, 32'h33, 32'h33, 16'hFFFF);
    do_one("lw", 6'd35, 32'd0, 32'h2B, 32'd0, 16'hFFFC);
    do_one("sw", 6'd43, 32'd0, 32'h100, 32'd7, 16'h0010);
    do_one("addi", 6'd8, 32'd0, 32'hFFFF_FFFF, 32'd0, 16'h0001);
    do_one("unk", 6'd63, 32'd0, 32'd5, 32'd6, 16'h0020);

    // Multiply: 32 busy cycles, result on the 33rd, then held under backpressure.
    @(posedge clk); #1;
    opcode = 6'd0; pc = 32'h100; bus_a = 32'd7; bus_b = 32'd6; imm = 16'h0018;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("mul.in_rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    lat = 0; busy = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (!in_ready) busy++;
    end
    check("mul.lat", lat, 33);
    check("mul.busy", busy, 32);
    e = model(6'd0, 32'h100, 32'd7, 32'd6, 16'h0018);
    check("mul.alu42", alu_out, 32'd42);
    check_res("mul", e);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      opcode = 6'd0; bus_a = 32'd1; bus_b = 32'd1; imm = 16'h0020; in_valid = 1'b1;
      @(negedge clk);
      check("mul.hold_vld", out_valid, 1'b1);
      check("mul.hold_alu", alu_out, 32'd42);
      check("mul.hold_rdy", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("mul.drain_rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mul.drained", out_valid, 1'b0);

    // Reset in the middle of a multiply abandons it.
    @(posedge clk); #1;
    opcode = 6'd0; pc = 32'd0; bus_a = 32'd5; bus_b = 32'd9; imm = 16'h0018;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("rmul.in_rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rmul.rst_rdy", in_ready, 1'b0);
    check("rmul.rst_vld", out_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rmul.rel_rdy", in_ready, 1'b1);
    check("rmul.rel_vld", out_valid, 1'b0);
    check("rmul.rel_alu", alu_out, 32'd0);
    ghost = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) ghost++;
    end
    check("rmul.ghost", ghost, 0);

    // Back-to-back adds, one result per cycle.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      opcode = 6'd0; pc = 32'd0; bus_a = 32'(i * 10 + 1); bus_b = 32'(i); imm = 16'h0020;
      in_valid = (i < 5); out_ready = 1'b1;
      @(negedge clk);
      if (i < 5) check("b2b.in_rdy", in_ready, 1'b1);
      if (i > 0) begin
        check("b2b.vld", out_valid, 1'b1);
        check("b2b.alu", alu_out, 32'((i - 1) * 11 + 1));
      end
    end

    // Random traffic with random backpressure against the scoreboard.
    @(posedge clk); #1;
    in_valid = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk); #1;
      if (!in_valid || acc_seen) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_txn();
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(posedge clk);
    @(negedge clk);
    check("sb.empty", exp_q.size(), 0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
